// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache lookup arbiter.
package cache_arb_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter_rr_pick.sv
// Round-robin picker: first requester set, scanning upward from last_i+1 and wrapping.
module rr_pick
  import cache_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_i,
  output logic [$clog2(N_REQ)-1:0] grant_o,
  output logic                     any_o
);

  localparam int IDX_W = $clog2(N_REQ);

  // Scan from the farthest offset down so the nearest requester after last_i wins.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    for (int off = N_REQ; off >= 1; off--) begin
      if (req_i[(int'(last_i) + off) % N_REQ]) begin
        grant_o = IDX_W'((int'(last_i) + off) % N_REQ);
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache lookup port; optional WAIT timeout abort
// is enabled by defining CACHE_ARB_TIMEOUT_EN.
//
// state    | meaning
// ARB_IDLE | no lookup in flight, arbitrate and accept
// ARB_WAIT | cache_miss high, waiting for cache_done (or timeout)
// ARB_RESP | one-cycle response strobe to the granted requester
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int ADDR_LENGTH = 10,
  parameter int TIMEOUT     = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*ADDR_LENGTH-1:0] req_addr,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [WORD_W-1:0]            rsp_data,
  output logic                         rsp_err,
  output logic                         cache_miss,
  output logic [ADDR_LENGTH-1:0]       cache_addr,
  input  logic                         cache_done,
  input  logic [WORD_W-1:0]            cache_data,
  output logic                         busy
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || TIMEOUT < 2) begin : g_param_check
    $error("cache_arbiter: N_REQ must be >= 2 and TIMEOUT >= 2");
  end

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [ADDR_LENGTH-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]      data_q, data_d;
  logic [IDX_W-1:0]       pick;
  logic                   any_req;

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timeout;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i   (req_valid),
    .last_i  (last_q),
    .grant_o (pick),
    .any_o   (any_req)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    data_d    = data_q;
    req_ready = '0;
`ifdef CACHE_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          req_ready[pick] = 1'b1;
          grant_d         = pick;
          addr_d          = req_addr[int'(pick)*ADDR_LENGTH +: ADDR_LENGTH];
          state_d         = ARB_WAIT;
`ifdef CACHE_ARB_TIMEOUT_EN
          cnt_d           = '0;
`endif
        end
      end
      ARB_WAIT: begin
`ifdef CACHE_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        // cache_done takes precedence over a timeout in the same cycle.
        if (cache_done) begin
          data_d  = cache_data;
          state_d = ARB_RESP;
`ifdef CACHE_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (timeout) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ARB_RESP;
`endif
        end
      end
      ARB_RESP: begin
        last_d  = grant_q;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      addr_q  <= '0;
      data_q  <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef CACHE_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == ARB_RESP) rsp_valid[grant_q] = 1'b1;
  end

  assign cache_miss = (state_q == ARB_WAIT);
  assign cache_addr = addr_q;
  assign rsp_data   = data_q;
  assign busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a delay-programmable cache model.
module tb_cache_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [19:0] req_addr;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        cache_miss;
  logic [9:0]  cache_addr;
  logic        cache_done;
  logic [31:0] cache_data;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  int          model_delay = -1;
  logic [31:0] model_data = 32'h0;
  int          wcnt = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.N_REQ(2), .ADDR_LENGTH(10), .TIMEOUT(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .cache_miss (cache_miss),
    .cache_addr (cache_addr),
    .cache_done (cache_done),
    .cache_data (cache_data),
    .busy       (busy)
  );

  // Cache model: done in the model_delay-th cycle of a continuous cache_miss high run.
  initial begin
    cache_done = 1'b0;
    cache_data = 32'h0;
    forever begin
      @(negedge clk);
      if (cache_miss) wcnt++;
      else wcnt = 0;
      cache_done = cache_miss && (wcnt == model_delay);
      cache_data = cache_done ? model_data : (32'hBAD0_0000 | 32'(wcnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_txn(input logic [1:0] rv, input logic [9:0] a0, input logic [9:0] a1,
                         input int dly, input logic [31:0] d, input int hold,
                         input logic [1:0] exp_g, input logic [9:0] exp_a, input int exp_miss,
                         input logic exp_err, input logic [31:0] exp_d, input string tag);
    int   misses;
    logic addr_ok, ready_ok, seen;
    @(negedge clk);
    req_valid   = rv;
    req_addr    = {a1, a0};
    model_delay = dly;
    model_data  = d;
    #1;
    chk({tag, " req_ready"}, 32'(req_ready), 32'(exp_g));
    @(negedge clk);
    misses = 0; addr_ok = 1'b1; ready_ok = 1'b1; seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c >= hold) req_valid = 2'b00;
      if (rsp_valid != 2'b00) begin
        seen = 1'b1;
        break;
      end
      if (cache_miss) begin
        misses++;
        if (cache_addr !== exp_a) addr_ok = 1'b0;
      end
      if (req_ready !== 2'b00) ready_ok = 1'b0;
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk({tag, " rsp seen"}, 32'(seen), 32'd1);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(exp_g));
    chk({tag, " rsp_data"}, rsp_data, exp_d);
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, " miss cycles"}, 32'(misses), 32'(exp_miss));
    chk({tag, " cache_addr stable"}, 32'(addr_ok), 32'd1);
    chk({tag, " no ready in wait"}, 32'(ready_ok), 32'd1);
    @(negedge clk);
    chk({tag, " strobe one cycle"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rsp_data held"}, rsp_data, exp_d);
  endtask

  typedef struct {
    logic [1:0]  rv;
    logic [9:0]  a0;
    logic [9:0]  a1;
    int          dly;
    logic [31:0] data;
    logic [1:0]  exp_g;
    logic [9:0]  exp_a;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [1:0] grants[4];
    logic [9:0] addrs[4];
    int         nresp, nlook, low;
    logic       prev_miss, gaps_ok;

    // last_grant starts at 1 after reset; each row follows from the previous row's grant.
    vecs[0] = '{2'b01, 10'd50,   10'd0,   20, 32'hDEADBEEF, 2'b01, 10'd50};
    vecs[1] = '{2'b11, 10'd4,    10'd8,    5, 32'h00001111, 2'b10, 10'd8};
    vecs[2] = '{2'b11, 10'd4,    10'd8,    1, 32'h22223333, 2'b01, 10'd4};
    vecs[3] = '{2'b10, 10'd0,    10'd300,  3, 32'h0000CAFE, 2'b10, 10'd300};
    vecs[4] = '{2'b10, 10'd0,    10'd300,  2, 32'h000055AA, 2'b10, 10'd300};
    vecs[5] = '{2'b01, 10'd1023, 10'd0,    7, 32'hFFFFFFFF, 2'b01, 10'd1023};

    reset = 1'b0; req_valid = 2'b00; req_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset cache_miss", 32'(cache_miss), 32'd0);
    chk("reset rsp_data", rsp_data, 32'd0);
    chk("reset cache_addr", 32'(cache_addr), 32'd0);

    // Reset during WAIT aborts silently.
    @(negedge clk);
    req_valid = 2'b01; req_addr = {10'd0, 10'd77}; model_delay = -1;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    chk("pre-reset busy", 32'(busy), 32'd1);
    apply_reset();
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset cache_miss", 32'(cache_miss), 32'd0);
    chk("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset rsp_err", 32'(rsp_err), 32'd0);
    chk("midreset rsp_data", rsp_data, 32'd0);
    chk("midreset cache_addr", 32'(cache_addr), 32'd0);
    chk("midreset req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("midreset no late rsp", 32'(rsp_valid), 32'd0);

    // Both requesters held: alternating grants, two-cycle cache_miss gap.
    req_valid = 2'b11; req_addr = {10'd8, 10'd4}; model_delay = 5; model_data = 32'h0B0B;
    nresp = 0; nlook = 0; low = 0; prev_miss = 1'b0; gaps_ok = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (cache_miss) begin
        if (!prev_miss) begin
          if (nlook > 0 && low != 2) gaps_ok = 1'b0;
          if (nlook < 4) addrs[nlook] = cache_addr;
          nlook++;
        end
        low = 0;
      end else begin
        low++;
      end
      if (rsp_valid != 2'b00) begin
        if (nresp < 4) grants[nresp] = rsp_valid;
        nresp++;
        if (nresp == 4) break;
      end
      prev_miss = cache_miss;
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("b2b responses", 32'(nresp), 32'd4);
    chk("b2b grant0", 32'(grants[0]), 32'h1);
    chk("b2b grant1", 32'(grants[1]), 32'h2);
    chk("b2b grant2", 32'(grants[2]), 32'h1);
    chk("b2b grant3", 32'(grants[3]), 32'h2);
    chk("b2b addr0", 32'(addrs[0]), 32'd4);
    chk("b2b addr1", 32'(addrs[1]), 32'd8);
    chk("b2b addr2", 32'(addrs[2]), 32'd4);
    chk("b2b addr3", 32'(addrs[3]), 32'd8);
    chk("b2b miss gap", 32'(gaps_ok), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].rv, vecs[i].a0, vecs[i].a1, vecs[i].dly, vecs[i].data, 0,
              vecs[i].exp_g, vecs[i].exp_a, vecs[i].dly, 1'b0, vecs[i].data,
              $sformatf("vec%0d", i));
    end

    // Done arriving in WAIT cycle 64 beats a coinciding timeout.
    run_txn(2'b10, 10'd0, 10'd77, 64, 32'h00001234, 0, 2'b10, 10'd77, 64, 1'b0,
            32'h00001234, "done at 64");

    // Requester 1 drops its request mid-WAIT; the response still goes out.
    run_txn(2'b10, 10'd0, 10'd99, 10, 32'h000000A5, 3, 2'b10, 10'd99, 10, 1'b0,
            32'h000000A5, "dropped req");

`ifdef CACHE_ARB_TIMEOUT_EN
    run_txn(2'b01, 10'd5, 10'd0, -1, 32'h0, 0, 2'b01, 10'd5, 64, 1'b1, 32'h0, "timeout");
`else
    @(negedge clk);
    req_valid = 2'b01; req_addr = {10'd0, 10'd5}; model_delay = -1;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (200) @(negedge clk);
    chk("no timeout busy", 32'(busy), 32'd1);
    chk("no timeout cache_miss", 32'(cache_miss), 32'd1);
    chk("no timeout rsp_valid", 32'(rsp_valid), 32'd0);
    apply_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
